// File: rtl/nn_training_sequencer.sv
// Training-run sequencer for neural_network: initial reset, parameter load, sample streaming, drain and epoch reset.
// Optional feature macro NN_SEQ_ABORT_EN adds an `abort` input that cancels a run through a network-reset ABORT state.
module nn_training_sequencer #(
    parameter int DATA_W         = 16,
    parameter int L1             = 2,
    parameter int L4             = 1,
    parameter int SIZE_OF_X      = 2048,
    parameter int EPOCHS         = 100,
    parameter int HOLD_CYCLES    = 10,
    parameter int DRAIN_CYCLES   = 200,
    parameter int NET_RST_CYCLES = 10,
    localparam int ADDR_W        = (SIZE_OF_X > 1) ? $clog2(SIZE_OF_X) : 1,
    localparam int EP_W          = $clog2(EPOCHS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
`ifdef NN_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [L1*DATA_W-1:0] s_a1,
    input  logic [L4*DATA_W-1:0] s_y,
    output logic [ADDR_W-1:0]    sample_addr,
    output logic                 net_reset,
    output logic                 block_reset_on_mux,
    output logic                 load_inital_parameters,
    output logic                 input_select,
    output logic                 en_forward,
    output logic                 en_backward,
    output logic [L1*DATA_W-1:0] a1,
    output logic [L4*DATA_W-1:0] y,
    output logic [EP_W-1:0]      epoch_cnt,
    output logic                 busy,
    output logic                 done
);

    localparam int MAX_A   = (NET_RST_CYCLES > HOLD_CYCLES) ? NET_RST_CYCLES : HOLD_CYCLES;
    localparam int MAX_CNT = (MAX_A > DRAIN_CYCLES) ? MAX_A : DRAIN_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0]  RST_LAST   = CNT_W'(NET_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(SIZE_OF_X - 1);
    localparam logic [EP_W-1:0]   LAST_EPOCH = EP_W'(EPOCHS - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_RST,
        ST_LOAD,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN,
        ST_EPOCH_RST,
        ST_DONE,
        ST_ABORT
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [EP_W-1:0]      epoch_q, epoch_d;
    logic                 s_ready_q, s_ready_d;
    logic                 net_reset_q, net_reset_d;
    logic                 brm_q, brm_d;
    logic                 load_q, load_d;
    logic                 sel_q, sel_d;
    logic                 en_q, en_d;
    logic [L1*DATA_W-1:0] a1_q, a1_d;
    logic [L4*DATA_W-1:0] y_q, y_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Every output is a flop; the next-state logic computes the levels the network sees next cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        epoch_d     = epoch_q;
        s_ready_d   = s_ready_q;
        net_reset_d = net_reset_q;
        brm_d       = brm_q;
        load_d      = 1'b0;
        sel_d       = sel_q;
        en_d        = en_q;
        a1_d        = a1_q;
        y_d         = y_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_INIT_RST;
                    cnt_d       = '0;
                    idx_d       = '0;
                    epoch_d     = '0;
                    net_reset_d = 1'b0;
                    brm_d       = 1'b0;
                    sel_d       = 1'b0;
                    en_d        = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ST_INIT_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d     = ST_LOAD;
                    net_reset_d = 1'b1;
                    brm_d       = 1'b1;
                    load_d      = 1'b1;
                    sel_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                state_d   = ST_FETCH;
                en_d      = 1'b1;
                s_ready_d = 1'b1;
            end
            ST_FETCH: begin
                // An underrun stalls the network; enables come back with the latched sample.
                if (s_valid) begin
                    state_d   = ST_HOLD;
                    cnt_d     = '0;
                    a1_d      = s_a1;
                    y_d       = s_y;
                    s_ready_d = 1'b0;
                    en_d      = 1'b1;
                end else begin
                    en_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                        idx_d   = '0;
                    end else begin
                        state_d   = ST_FETCH;
                        idx_d     = idx_q + ADDR_W'(1);
                        s_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    epoch_d = epoch_q + EP_W'(1);
                    if (epoch_q == LAST_EPOCH) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        en_d    = 1'b0;
                    end else begin
                        state_d     = ST_EPOCH_RST;
                        net_reset_d = 1'b0;
                        sel_d       = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EPOCH_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d     = ST_FETCH;
                    net_reset_d = 1'b1;
                    s_ready_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                net_reset_d = 1'b0;
                busy_d      = 1'b0;
            end
`ifdef NN_SEQ_ABORT_EN
            ST_ABORT: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_IDLE;
                    brm_d   = 1'b0;
                    sel_d   = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef NN_SEQ_ABORT_EN
        // Abort overrides whatever the current state decided, but keeps the progress counters.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_ABORT;
            cnt_d       = '0;
            idx_d       = idx_q;
            epoch_d     = epoch_q;
            s_ready_d   = 1'b0;
            net_reset_d = 1'b0;
            brm_d       = brm_q;
            load_d      = 1'b0;
            sel_d       = sel_q;
            en_d        = 1'b0;
            a1_d        = a1_q;
            y_d         = y_q;
            busy_d      = 1'b1;
            done_d      = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            epoch_q     <= '0;
            s_ready_q   <= 1'b0;
            net_reset_q <= 1'b0;
            brm_q       <= 1'b0;
            load_q      <= 1'b0;
            sel_q       <= 1'b0;
            en_q        <= 1'b0;
            a1_q        <= '0;
            y_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            epoch_q     <= epoch_d;
            s_ready_q   <= s_ready_d;
            net_reset_q <= net_reset_d;
            brm_q       <= brm_d;
            load_q      <= load_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            a1_q        <= a1_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign s_ready                = s_ready_q;
    assign sample_addr            = idx_q;
    assign net_reset              = net_reset_q;
    assign block_reset_on_mux     = brm_q;
    assign load_inital_parameters = load_q;
    assign input_select           = sel_q;
    assign en_forward             = en_q;
    assign en_backward            = en_q;
    assign a1                     = a1_q;
    assign y                      = y_q;
    assign epoch_cnt              = epoch_q;
    assign busy                   = busy_q;
    assign done                   = done_q;

endmodule

// File: tb/tb_nn_training_sequencer.sv
// Self-checking bench for nn_training_sequencer: a run-level model builds a per-cycle stimulus/expectation schedule.
// Define NN_SEQ_ABORT_EN for both files to exercise the abort path as well.
module tb_nn_training_sequencer;

    localparam int DATA_W         = 16;
    localparam int L1             = 2;
    localparam int L4             = 1;
    localparam int SIZE_OF_X      = 4;
    localparam int EPOCHS         = 2;
    localparam int HOLD_CYCLES    = 3;
    localparam int DRAIN_CYCLES   = 5;
    localparam int NET_RST_CYCLES = 2;
    localparam int ADDR_W         = $clog2(SIZE_OF_X);
    localparam int EP_W           = $clog2(EPOCHS + 1);
    localparam int A1_W           = L1 * DATA_W;
    localparam int Y_W            = L4 * DATA_W;

    // Busy cycles of an uninterrupted run with no source underruns.
    localparam int BASE_LEN = NET_RST_CYCLES + 1
                            + EPOCHS * (SIZE_OF_X * (HOLD_CYCLES + 1) + DRAIN_CYCLES)
                            + (EPOCHS - 1) * NET_RST_CYCLES + 1;

    typedef struct packed {
        logic            reset;
        logic            start;
        logic            s_valid;
        logic            abort;
        logic [A1_W-1:0] s_a1;
        logic [Y_W-1:0]  s_y;
    } stim_t;

    typedef struct packed {
        logic              check;
        logic              s_ready;
        logic              net_reset;
        logic              brm;
        logic              load;
        logic              sel;
        logic              en;
        logic              busy;
        logic              done;
        logic [ADDR_W-1:0] addr;
        logic [EP_W-1:0]   epoch;
        logic [A1_W-1:0]   a1;
        logic [Y_W-1:0]    y;
    } expect_t;

    logic            clk;
    logic            reset;
    logic            start;
    logic            s_valid;
    logic            s_ready;
    logic [A1_W-1:0] s_a1;
    logic [Y_W-1:0]  s_y;
    logic [ADDR_W-1:0] sample_addr;
    logic            net_reset;
    logic            block_reset_on_mux;
    logic            load_inital_parameters;
    logic            input_select;
    logic            en_forward;
    logic            en_backward;
    logic [A1_W-1:0] a1;
    logic [Y_W-1:0]  y;
    logic [EP_W-1:0] epoch_cnt;
    logic            busy;
    logic            done;
`ifdef NN_SEQ_ABORT_EN
    logic            abort;
`endif

    stim_t   stimQ[$];
    expect_t expQ[$];
    expect_t cur;

    int checkCount;
    int errorCount;
    int cycle;
    int holdMark;
    int drainMark;
    int runAStart;
    int runAEnd;
    int runAGaps;
    int obsBusy;
    int obsEnLow;
    int obsDone;

    nn_training_sequencer #(
        .DATA_W         (DATA_W),
        .L1             (L1),
        .L4             (L4),
        .SIZE_OF_X      (SIZE_OF_X),
        .EPOCHS         (EPOCHS),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .DRAIN_CYCLES   (DRAIN_CYCLES),
        .NET_RST_CYCLES (NET_RST_CYCLES)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .start                  (start),
`ifdef NN_SEQ_ABORT_EN
        .abort                  (abort),
`endif
        .s_valid                (s_valid),
        .s_ready                (s_ready),
        .s_a1                   (s_a1),
        .s_y                    (s_y),
        .sample_addr            (sample_addr),
        .net_reset              (net_reset),
        .block_reset_on_mux     (block_reset_on_mux),
        .load_inital_parameters (load_inital_parameters),
        .input_select           (input_select),
        .en_forward             (en_forward),
        .en_backward            (en_backward),
        .a1                     (a1),
        .y                      (y),
        .epoch_cnt              (epoch_cnt),
        .busy                   (busy),
        .done                   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cycle, observed, expected);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        reset   = s.reset;
        start   = s.start;
        s_valid = s.s_valid;
        s_a1    = s.s_a1;
        s_y     = s.s_y;
`ifdef NN_SEQ_ABORT_EN
        abort   = s.abort;
`endif
    endtask

    task automatic checkCycle(input expect_t e);
        checkOutput("ctrl",
            64'({s_ready, net_reset, block_reset_on_mux, load_inital_parameters,
                 input_select, en_forward, en_backward, busy, done}),
            64'({e.s_ready, e.net_reset, e.brm, e.load, e.sel, e.en, e.en, e.busy, e.done}));
        checkOutput("sample_addr", 64'(sample_addr), 64'(e.addr));
        checkOutput("epoch_cnt", 64'(epoch_cnt), 64'(e.epoch));
        checkOutput("a1", 64'(a1), 64'(e.a1));
        checkOutput("y", 64'(y), 64'(e.y));
    endtask

    // Random don't-care traffic; start pulses only land while the sequencer is busy.
    function automatic stim_t busyStim();
        stim_t s;
        s.reset   = 1'b0;
        s.abort   = 1'b0;
        s.start   = ($urandom_range(0, 5) == 0);
        s.s_valid = 1'($urandom_range(0, 1));
        s.s_a1    = A1_W'($urandom);
        s.s_y     = Y_W'($urandom);
        return s;
    endfunction

    function automatic stim_t idleStim();
        stim_t s;
        s       = busyStim();
        s.start = 1'b0;
        return s;
    endfunction

    // Record one cycle: the inputs driven during it and the outputs expected during it.
    task automatic emit(input stim_t s);
        expect_t e;
        e       = cur;
        e.check = 1'b1;
        stimQ.push_back(s);
        expQ.push_back(e);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) emit(idleStim());
    endtask

    task automatic truncateAfter(input int idx);
        while (stimQ.size() > idx + 1) begin
            void'(stimQ.pop_back());
            void'(expQ.pop_back());
        end
    endtask

    // One training run described phase by phase: reset, load, per-sample fetch/hold, drain, epoch reset, done.
    task automatic buildRun(input bit directed, output int gapsTotal);
        stim_t s;
        int    gaps;
        gapsTotal = 0;
        s = idleStim();
        s.start = 1'b1;
        emit(s);
        cur.busy = 1'b1; cur.epoch = '0; cur.addr = '0;
        cur.net_reset = 1'b0; cur.brm = 1'b0; cur.sel = 1'b0; cur.en = 1'b0;
        for (int i = 0; i < NET_RST_CYCLES; i++) emit(busyStim());
        cur.net_reset = 1'b1; cur.brm = 1'b1; cur.load = 1'b1; cur.sel = 1'b0;
        emit(busyStim());
        cur.load = 1'b0; cur.en = 1'b1;
        for (int e = 0; e < EPOCHS; e++) begin
            for (int x = 0; x < SIZE_OF_X; x++) begin
                cur.s_ready = 1'b1;
                cur.addr    = ADDR_W'(x);
                if (directed) gaps = (e == 0 && x == 2) ? 7 : 0;
                else          gaps = $urandom_range(0, 2);
                gapsTotal += gaps;
                for (int g = 0; g < gaps; g++) begin
                    s = busyStim();
                    s.s_valid = 1'b0;
                    emit(s);
                    cur.en = 1'b0;
                end
                s = busyStim();
                s.s_valid = 1'b1;
                if (directed && e == 0 && x == 0) begin
                    s.s_a1[0 +: DATA_W]      = DATA_W'(-4750);
                    s.s_a1[DATA_W +: DATA_W] = DATA_W'(1013);
                    s.s_y                    = Y_W'(4096);
                end
                if (directed && e == 0 && x == 1) begin
                    s.s_a1[0 +: DATA_W]      = DATA_W'(250);
                    s.s_a1[DATA_W +: DATA_W] = DATA_W'(-1555);
                end
                emit(s);
                cur.s_ready = 1'b0; cur.en = 1'b1; cur.a1 = s.s_a1; cur.y = s.s_y;
                for (int h = 0; h < HOLD_CYCLES; h++) begin
                    if (e == EPOCHS - 1 && x == 1 && h == 1) holdMark = stimQ.size();
                    emit(busyStim());
                end
            end
            cur.addr = '0;
            for (int d = 0; d < DRAIN_CYCLES; d++) begin
                if (e == EPOCHS - 1 && d == 2) drainMark = stimQ.size();
                emit(busyStim());
            end
            cur.epoch = EP_W'(e + 1);
            if (e < EPOCHS - 1) begin
                cur.net_reset = 1'b0; cur.sel = 1'b1;
                for (int r = 0; r < NET_RST_CYCLES; r++) emit(busyStim());
                cur.net_reset = 1'b1;
            end
        end
        cur.done = 1'b1; cur.en = 1'b0;
        emit(busyStim());
        cur.done = 1'b0; cur.busy = 1'b0; cur.net_reset = 1'b0;
    endtask

    task automatic buildSchedule();
        stim_t   s;
        expect_t e;
        int      gaps;
        s = idleStim();
        s.reset = 1'b1;
        e = cur;
        e.check = 1'b0;
        stimQ.push_back(s);
        expQ.push_back(e);
        cur = '0;
        emit(s);
        idleCycles(3);

        runAStart = stimQ.size();
        buildRun(1'b1, runAGaps);
        runAEnd = stimQ.size();
        idleCycles(4);

        // Second run is cut short by a reset in the middle of a hold window.
        buildRun(1'b0, gaps);
        truncateAfter(holdMark);
        s = stimQ[holdMark];
        s.reset = 1'b1;
        stimQ[holdMark] = s;
        cur = '0;
        idleCycles(3);

        buildRun(1'b0, gaps);
        idleCycles(3);

`ifdef NN_SEQ_ABORT_EN
        buildRun(1'b0, gaps);
        truncateAfter(drainMark);
        s = stimQ[drainMark];
        s.abort = 1'b1;
        stimQ[drainMark] = s;
        cur = expQ[drainMark];
        cur.s_ready = 1'b0; cur.net_reset = 1'b0; cur.en = 1'b0;
        cur.load = 1'b0; cur.done = 1'b0; cur.busy = 1'b1;
        for (int i = 0; i < NET_RST_CYCLES; i++) emit(busyStim());
        cur.busy = 1'b0; cur.brm = 1'b0; cur.sel = 1'b0;
        idleCycles(3);
        buildRun(1'b0, gaps);
        idleCycles(2);
`endif
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        cycle      = 0;
        holdMark   = 0;
        drainMark  = 0;
        obsBusy    = 0;
        obsEnLow   = 0;
        obsDone    = 0;
        reset      = 1'b1;
        start      = 1'b0;
        s_valid    = 1'b0;
        s_a1       = '0;
        s_y        = '0;
`ifdef NN_SEQ_ABORT_EN
        abort      = 1'b0;
`endif
        cur = '0;
        buildSchedule();
        $display("[TB] schedule holds %0d cycles", stimQ.size());

        for (int k = 0; k < stimQ.size(); k++) begin
            @(negedge clk);
            cycle = k;
            if (expQ[k].check) checkCycle(expQ[k]);
            if (k >= runAStart && k < runAEnd) begin
                if (busy) obsBusy++;
                if (busy && !en_forward && !en_backward) obsEnLow++;
                if (done) obsDone++;
            end
            applyStimulus(stimQ[k]);
        end

        checkOutput("runA_gaps", 64'(runAGaps), 64'(7));
        checkOutput("runA_busy_len", 64'(obsBusy), 64'(BASE_LEN + 7));
        checkOutput("runA_en_low", 64'(obsEnLow), 64'(NET_RST_CYCLES + 1 + 7 + 1));
        checkOutput("runA_done_pulses", 64'(obsDone), 64'(1));

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/nn_training_sequencer.md
Name: nn_training_sequencer

Overview:
- Sequences `neural_network` through a complete training run: initial reset, parameter load, per-sample streaming of `a1`/`y`, inter-epoch drain and network reset, then switch to UPDATE parameters.
- Replaces the hand-timed stimulus with synthesizable control.
- Sits between a sample source (BRAM/DMA reader, valid/ready) and the `neural_network` control/data inputs.

Parameters:
- DATA_W, 16, width of one data_type element
- L1, 2, input-layer width (elements in `a1`)
- L4, 1, output-layer width (elements in `y`)
- SIZE_OF_X, 2048, samples per epoch
- EPOCHS, 100, number of epochs
- HOLD_CYCLES, 10, cycles each sample is held on `a1`/`y`
- DRAIN_CYCLES, 200, cycles waited after the last sample of an epoch
- NET_RST_CYCLES, 10, cycles `net_reset` is held low

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high block reset
- start  in  1  one-cycle pulse; begins a run from IDLE
- s_valid  in  1  sample source has data
- s_ready  out  1  sequencer accepts a sample
- s_a1  in  L1*DATA_W  sample inputs, element i at [i*DATA_W +: DATA_W]
- s_y  in  L4*DATA_W  expected outputs, same packing as `s_a1`
- sample_addr  out  $clog2(SIZE_OF_X)  index of the requested sample
- net_reset  out  1  active-low reset to `neural_network`
- block_reset_on_mux  out  1  to `neural_network`
- load_inital_parameters  out  1  to `neural_network`
- input_select  out  1  0 = INITIAL_INPUT, 1 = UPDATE
- en_forward  out  1  to `neural_network`
- en_backward  out  1  to `neural_network`
- a1  out  L1*DATA_W  registered sample to network
- y  out  L4*DATA_W  registered expected output to network
- epoch_cnt  out  $clog2(EPOCHS+1)  completed epochs
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset values (reset=1 at a clk edge; all outputs registered):
  - net_reset=0, all other control outputs 0
  - a1/y=0, sample_addr=0, epoch_cnt=0, s_ready=0
  - state=IDLE
- Reset mid-run aborts immediately to these values.

- States:
  - IDLE
    - net_reset=0; all other control outputs 0.
    - start=1 → INIT_RST.
    - start while busy is ignored.
  - INIT_RST
    - net_reset=0 for NET_RST_CYCLES cycles, then net_reset=1 and block_reset_on_mux=1 → LOAD.
  - LOAD
    - input_select=0; load_inital_parameters=1 for exactly one cycle.
    - Next cycle: en_forward=en_backward=1 → FETCH.
  - FETCH
    - s_ready=1; sample_addr = current sample index.
    - On s_valid && s_ready: latch s_a1→a1 and s_y→y, s_ready=0 → HOLD.
    - While s_valid=0 (underrun): en_forward/en_backward=0, a1/y keep their last values.
    - Enables return to 1 in the cycle the new sample is latched.
  - HOLD
    - Counts HOLD_CYCLES cycles, first cycle = latch cycle.
    - Then increments the sample index.
    - Index ≠ SIZE_OF_X-1 → FETCH.
    - Index = SIZE_OF_X-1 → DRAIN, sample index wraps to 0.
  - DRAIN
    - Enables stay 1 for DRAIN_CYCLES cycles; epoch_cnt increments on exit.
    - New epoch_cnt = EPOCHS → DONE; otherwise → EPOCH_RST.
  - EPOCH_RST
    - net_reset=0 for NET_RST_CYCLES cycles; input_select=1 from entry onward.
    - block_reset_on_mux stays 1; enables stay 1.
    - Then net_reset=1 → FETCH.
  - DONE
    - done=1 for one cycle.
    - en_forward/en_backward=0, block_reset_on_mux stays 1 (trained parameters retained), input_select stays 1.
    - → IDLE; IDLE keeps these levels until the next start.

- Latency: start to first s_ready = NET_RST_CYCLES+2 cycles.
- Steady state: one sample per HOLD_CYCLES+1 cycles with s_valid held high (1 FETCH cycle + HOLD_CYCLES).
- Counters are free of overflow for all legal parameters; SIZE_OF_X=1 and EPOCHS=1 are legal.
- Simultaneous reset and start: reset wins.

Optional Feature:
- Macro: NN_SEQ_ABORT_EN.
- When defined:
  - Extra input port `abort` (1 bit).
  - abort=1 in any non-IDLE state → ABORT state: en_forward/en_backward=0, net_reset=0 for NET_RST_CYCLES cycles.
  - Then IDLE with block_reset_on_mux=0 and input_select=0.
  - done is not pulsed; epoch_cnt holds its value until the next start clears it.
  - abort has priority over start and over normal transitions; reset has priority over abort.
- When undefined: no `abort` port; runs end only via DONE or reset.

Test Plan:
- Params SIZE_OF_X=4, EPOCHS=2, HOLD_CYCLES=3, DRAIN_CYCLES=5, NET_RST_CYCLES=2; source always valid. Pulse start → net_reset low exactly 2 cycles, one-cycle load pulse with input_select=0, 4 samples (addr 0..3) each held 4 cycles, drain 5, EPOCH_RST with input_select=1, second epoch, done pulse once, epoch_cnt=2.
- Sample values a1={-4750,1013}, y=4096 at addr 0 and a1={250,-1555} at addr 1 → a1/y outputs match exactly during the corresponding HOLD windows.
- Deassert s_valid for 7 cycles at addr 2 → en_forward/en_backward low for exactly those cycles, a1 holds the addr-1 value, total run lengthens by 7 cycles.
- Assert reset during HOLD of epoch 1 → next cycle all outputs at reset values; a subsequent start repeats the full sequence from addr 0 with input_select=0.
- Pulse start while busy → no effect on the sample or epoch sequence.
- With NN_SEQ_ABORT_EN, assert abort in DRAIN → enables drop next cycle, net_reset low 2 cycles, IDLE, no done pulse, epoch_cnt unchanged.
